gold_code_top: RTL and testbench
================================

# gold_code_top

Top level of the DSP code generator. It holds two 6-stage Fibonacci LFSR maximal-length (m-)sequence generators whose seeds come from the `code1`/`code2` ports. It XORs their serial outputs into a 1-bit Gold-type chip stream `code_gold`, repeating every 63 chips. `ready` marks the seed-load cycle between periods.

## Interface
- `TAPS_A`, default 6'b000011: feedback mask of generator A, x^6+x+1.
- `TAPS_B`, default 6'b100111: feedback mask of generator B, x^6+x^5+x^2+x+1.
- `clkin`, input, 1: the single clock; all state updates on its rising edge.
- `rstn`, input, 1: asynchronous, active-high reset. The port keeps the codebase name; its polarity is high despite the name.
- `code1`, input, 6: seed for generator A, sampled only in the load cycle.
- `code2`, input, 6: seed for generator B, sampled only in the load cycle.
- `ready`, output, 1: high during the load cycle, when seeds are sampled.
- `code_gold`, output, 1: registered Gold chip, A.out XOR B.out.

## Operation
- Generator state is s[5:0].
  - Output bit = s[0].
  - Feedback f = XOR-reduce(s & TAPS).
  - Next state = {f, s[5:1]}.
- A zero seed would lock up the LFSR, so a seed of 6'b000000 is replaced by 6'b000001 at load. All other seeds load unchanged.
- Two-state FSM:
  - **LOAD** (`ready`=1): on the clock edge, A <= seed(code1), B <= seed(code2), chip counter <= 0, then go to RUN.
  - **RUN** (`ready`=0): on each edge, `code_gold` <= A.s[0] ^ B.s[0], both LFSRs shift, and the counter increments.
  - When counter = 62 at an edge (the 63rd chip), go to LOAD.
- `code_gold` holds its last value during LOAD.
- Seed changes while in RUN are ignored until the next LOAD.

## Timing
- Reset values: FSM=LOAD, `ready`=1, `code_gold`=0, counter=0, both LFSRs=6'b000001.
- After reset release, the first rising edge is the load edge.
- The first chip appears on `code_gold` one edge after the load edge.
- Period is 64 clocks: 1 LOAD cycle plus 63 RUN cycles. `ready` is high for exactly 1 cycle per period.
- Reset asserted mid-period returns immediately (asynchronously) to reset values. Partial periods are discarded.
- Counter is 6 bits and never exceeds 62.

## Configuration
- `GOLD_MSEQ_DEBUG_EN` defined: adds outputs `mseq_a` and `mseq_b`, each 1 bit. They are registered alongside `code_gold` and carry A.s[0] and B.s[0]. Their reset value is 0.
- Not defined: the ports are absent and the generator outputs are used only internally.

## Structure
- Package `gold_code_pkg` holds:
  - `SEED_W`=6 and `SEQ_LEN`=63;
  - default tap masks and `DEFAULT_SEED`=6'b000001;
  - the FSM state enum {LOAD, RUN}.
- Sub-module `m_sequence_gen`: a parameterized LFSR with ports clk, rst, load, seed[5:0], shift, out. It is instantiated twice, once with `TAPS_A` and once with `TAPS_B`.

## Test plan
- **Reset:** hold `rstn`=1 for 10 cycles -> `ready`=1, `code_gold`=0. Release -> `ready`=1 for 1 cycle, then 0.
- **Default seeds:** `code1`=6'b000000, `code2`=6'b000011 at load -> first three chips on `code_gold` are 0, 1, 0. The full 63-chip sequence matches a reference model.
- **Periodicity:** run 3 periods with constant seeds -> `ready` pulses every 64 clocks and the chip sequence repeats identically. Each m-sequence alone has 32 ones and 31 zeros per period.
- **Seed change mid-RUN:** change `code1` at chip 20 -> the current period is unaffected and the new seed takes effect after the next `ready`.
- **Reset mid-period:** assert `rstn` at chip 30 -> outputs return asynchronously to reset values, and the restart matches the post-reset sequence.
- **Debug build:** with `GOLD_MSEQ_DEBUG_EN` defined -> `mseq_a ^ mseq_b` equals `code_gold` on every RUN cycle.

Source files
------------

// File: rtl/gold_code_pkg.sv
// Shared constants, state encoding and seed helper for the Gold code generator.
package gold_code_pkg;

   localparam int SEED_W  = 6;
   localparam int SEQ_LEN = 63;

   localparam logic [SEED_W-1:0] TAPS_A_DEF   = 6'b000011;
   localparam logic [SEED_W-1:0] TAPS_B_DEF   = 6'b100111;
   localparam logic [SEED_W-1:0] DEFAULT_SEED = 6'b000001;

   typedef enum logic {LOAD, RUN} state_t;

   // An all-zero LFSR never leaves zero, so it is swapped for a legal seed.
   function automatic logic [SEED_W-1:0] safe_seed(input logic [SEED_W-1:0] s);
      return (s == '0) ? DEFAULT_SEED : s;
   endfunction

endpackage

// File: rtl/m_sequence_gen.sv
// Parameterized 6-stage Fibonacci LFSR producing one m-sequence bit per shift.
module m_sequence_gen
   import gold_code_pkg::*;
#(
   parameter logic [SEED_W-1:0] TAPS = TAPS_A_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [SEED_W-1:0] seed,
   input  logic              shift,
   output logic              out
);

   logic [SEED_W-1:0] s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s <= DEFAULT_SEED;
      end else if (load) begin
         s <= seed;
      end else if (shift) begin
         s <= {^(s & TAPS), s[SEED_W-1:1]};
      end
   end

   assign out = s[0];

endmodule

// File: rtl/gold_code_top.sv
// Gold chip generator: two m-sequences XORed, reseeded every 63 chips.
// Optional GOLD_MSEQ_DEBUG_EN exposes the registered generator bits.
module gold_code_top
   import gold_code_pkg::*;
#(
   parameter logic [SEED_W-1:0] TAPS_A = TAPS_A_DEF,
   parameter logic [SEED_W-1:0] TAPS_B = TAPS_B_DEF
) (
   input  logic              clkin,
   input  logic              rstn,
   input  logic [SEED_W-1:0] code1,
   input  logic [SEED_W-1:0] code2,
   output logic              ready,
`ifdef GOLD_MSEQ_DEBUG_EN
   output logic              mseq_a,
   output logic              mseq_b,
`endif
   output logic              code_gold
);

   localparam logic [SEED_W-1:0] LAST = SEED_W'(SEQ_LEN - 1);

   state_t            state;
   state_t            nxt;
   logic [SEED_W-1:0] cnt;
   logic              load;
   logic              shift;
   logic              a_out;
   logic              b_out;
   logic [SEED_W-1:0] seed_a;
   logic [SEED_W-1:0] seed_b;

   assign seed_a = safe_seed(code1);
   assign seed_b = safe_seed(code2);

   always_ff @(posedge clkin or posedge rstn) begin
      if (rstn) begin
         state <= LOAD;
         cnt   <= '0;
      end else begin
         state <= nxt;
         if (load || cnt == LAST) begin
            cnt <= '0;
         end else if (shift) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_comb begin
      nxt   = state;
      load  = 1'b0;
      shift = 1'b0;
      ready = 1'b0;
      unique case (state)
         LOAD: begin
            ready = 1'b1;
            load  = 1'b1;
            nxt   = RUN;
         end
         RUN: begin
            shift = 1'b1;
            if (cnt == LAST) begin
               nxt = LOAD;
            end
         end
         default: nxt = LOAD;
      endcase
   end

   always_ff @(posedge clkin or posedge rstn) begin
      if (rstn) begin
         code_gold <= 1'b0;
      end else if (shift) begin
         code_gold <= a_out ^ b_out;
      end
   end

`ifdef GOLD_MSEQ_DEBUG_EN
   always_ff @(posedge clkin or posedge rstn) begin
      if (rstn) begin
         mseq_a <= 1'b0;
         mseq_b <= 1'b0;
      end else if (shift) begin
         mseq_a <= a_out;
         mseq_b <= b_out;
      end
   end
`endif

   m_sequence_gen #(.TAPS(TAPS_A)) u_gen_a (
      .clk  (clkin),
      .rst  (rstn),
      .load (load),
      .seed (seed_a),
      .shift(shift),
      .out  (a_out)
   );

   m_sequence_gen #(.TAPS(TAPS_B)) u_gen_b (
      .clk  (clkin),
      .rst  (rstn),
      .load (load),
      .seed (seed_b),
      .shift(shift),
      .out  (b_out)
   );

endmodule

// File: tb/tb_gold_code_top.sv
// Randomized self-checking bench for gold_code_top against a sequence-level model.
module tb_gold_code_top;
   import gold_code_pkg::*;

   logic       clkin = 1'b0;
   logic       rstn  = 1'b1;
   logic [5:0] code1 = 6'd0;
   logic [5:0] code2 = 6'd3;
   logic       ready;
   logic       code_gold;
`ifdef GOLD_MSEQ_DEBUG_EN
   logic       mseq_a;
   logic       mseq_b;
`endif

   int checks = 0;
   int errors = 0;

   gold_code_top dut (
      .clkin    (clkin),
      .rstn     (rstn),
      .code1    (code1),
      .code2    (code2),
      .ready    (ready),
`ifdef GOLD_MSEQ_DEBUG_EN
      .mseq_a   (mseq_a),
      .mseq_b   (mseq_b),
`endif
      .code_gold(code_gold)
   );

   always #5 clkin = ~clkin;

   // Bit sequence a[n] with a[n+6] = XOR of a[n+i] over the set tap bits i.
   function automatic logic [62:0] mseq(input logic [5:0] seed,
                                        input logic [5:0] taps);
      logic [68:0] a;
      a      = '0;
      a[5:0] = seed;
      for (int n = 0; n < 63; n++) a[n+6] = ^(taps & a[n+:6]);
      return a[62:0];
   endfunction

   function automatic logic [5:0] fix(input logic [5:0] s);
      return (s == 6'd0) ? 6'd1 : s;
   endfunction

   function automatic logic [62:0] gold(input logic [5:0] c1,
                                        input logic [5:0] c2);
      return mseq(fix(c1), TAPS_A_DEF) ^ mseq(fix(c2), TAPS_B_DEF);
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: phase 0 is the load cycle, phases 1..63 follow chip k-1.
   int          phase  = 0;
   logic        m_gold = 1'b0;
   logic        m_a    = 1'b0;
   logic        m_b    = 1'b0;
   logic [62:0] sa     = '0;
   logic [62:0] sb     = '0;

   always @(posedge clkin or posedge rstn) begin
      if (rstn) begin
         phase  <= 0;
         m_gold <= 1'b0;
         m_a    <= 1'b0;
         m_b    <= 1'b0;
      end else if (phase == 0) begin
         sa    <= mseq(fix(code1), TAPS_A_DEF);
         sb    <= mseq(fix(code2), TAPS_B_DEF);
         phase <= 1;
      end else begin
         m_a    <= sa[phase-1];
         m_b    <= sb[phase-1];
         m_gold <= sa[phase-1] ^ sb[phase-1];
         phase  <= (phase == 63) ? 0 : phase + 1;
      end
   end

   always @(negedge clkin) begin
      chk("ready", {63'd0, ready}, {63'd0, phase == 0});
      chk("code_gold", {63'd0, code_gold}, {63'd0, m_gold});
`ifdef GOLD_MSEQ_DEBUG_EN
      chk("mseq_a", {63'd0, mseq_a}, {63'd0, m_a});
      chk("mseq_b", {63'd0, mseq_b}, {63'd0, m_b});
      if (!ready) chk("dbg_xor", {63'd0, mseq_a ^ mseq_b}, {63'd0, code_gold});
`endif
   end

   // Called at a negedge; returns at the next period's load cycle.
   task automatic run_period(output logic [62:0] chips, input int chg_at,
                             input logic [5:0] chg_val);
      int n = 0;
      chips = '0;
      while (ready !== 1'b1 && n < 200) begin
         @(negedge clkin);
         n++;
      end
      chk("ready_wait", {63'd0, n >= 200}, 64'd0);
      @(negedge clkin);
      chk("run_after_load", {63'd0, ready}, 64'd0);
      for (int i = 0; i < 63; i++) begin
         @(negedge clkin);
         chips[i] = code_gold;
         if (i == chg_at) code1 = chg_val;
      end
      chk("period_64", {63'd0, ready}, 64'd1);
   endtask

   logic [62:0] p1, p2, p3, pr, pz;
   logic [62:0] g0;
   logic [5:0]  s1, s2;

   initial begin
      repeat (10) @(negedge clkin);
      chk("rst_ready", {63'd0, ready}, 64'd1);
      chk("rst_gold", {63'd0, code_gold}, 64'd0);

      chk("model_ones_a", 64'($countones(mseq(6'd1, TAPS_A_DEF))), 64'd32);
      chk("model_ones_b", 64'($countones(mseq(6'd3, TAPS_B_DEF))), 64'd32);
      g0 = gold(6'd0, 6'd3);
      chk("model_first3", {61'd0, g0[2:0]}, 64'b010);

      rstn = 1'b0;
      #1 chk("load_ready", {63'd0, ready}, 64'd1);
      @(negedge clkin);
      run_period(p1, -1, 6'd0);
      chk("dut_first3", {61'd0, p1[2:0]}, 64'b010);
      chk("period1", {1'b0, p1}, {1'b0, g0});

      run_period(p2, 20, 6'd45);
      chk("mid_change_ignored", {1'b0, p2}, {1'b0, p1});
      run_period(p3, -1, 6'd0);
      chk("new_seed", {1'b0, p3}, {1'b0, gold(6'd45, 6'd3)});

      code1 = 6'd0;
      run_period(p2, -1, 6'd0);
      chk("repeat_a", {1'b0, p2}, {1'b0, p1});
      run_period(p3, -1, 6'd0);
      chk("repeat_b", {1'b0, p3}, {1'b0, p1});

      for (int k = 0; k < 6; k++) begin
         code1 = 6'($urandom_range(0, 63));
         code2 = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 3) == 0) code1 = 6'd0;
         if ($urandom_range(0, 3) == 0) code2 = 6'd0;
         s1 = code1;
         s2 = code2;
         run_period(pr, int'($urandom_range(0, 62)), 6'($urandom));
         chk("rand_period", {1'b0, pr}, {1'b0, gold(s1, s2)});
      end

      code1 = 6'd0;
      code2 = 6'd3;
      repeat (31) @(negedge clkin);
      @(posedge clkin);
      #2 rstn = 1'b1;
      #1;
      chk("mid_rst_ready", {63'd0, ready}, 64'd1);
      chk("mid_rst_gold", {63'd0, code_gold}, 64'd0);
`ifdef GOLD_MSEQ_DEBUG_EN
      chk("mid_rst_dbg", {62'd0, mseq_a, mseq_b}, 64'd0);
`endif
      repeat (3) @(negedge clkin);
      rstn = 1'b0;
      run_period(pz, -1, 6'd0);
      chk("restart", {1'b0, pz}, {1'b0, p1});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
